// File: rtl/seq_phy_csr_responder.sv
// Avalon-MM CSR responder for PHY calibration control: two-cycle accesses, command strobe, sticky errors.
// Optional access counter at word address 3 is built when SEQ_PHY_CSR_ACCESS_CNT_EN is defined.
module seq_phy_csr_responder #(
    parameter int AVL_DATA_WIDTH = 32,
    parameter int AVL_ADDR_WIDTH = 16,
    parameter int NUM_SCRATCH    = 4,
    parameter int STATUS_WIDTH   = 8
) (
    input  logic                      avl_clk,
    input  logic                      avl_reset_n,
    input  logic [AVL_ADDR_WIDTH-1:0] avl_address,
    input  logic                      avl_write,
    input  logic [AVL_DATA_WIDTH-1:0] avl_writedata,
    input  logic                      avl_read,
    output logic [AVL_DATA_WIDTH-1:0] avl_readdata,
    output logic                      avl_waitrequest,
    input  logic [STATUS_WIDTH-1:0]   phy_status,
    input  logic                      cmd_busy,
    output logic                      cmd_go,
    output logic [3:0]                cmd_code,
    output logic                      err_irq,
    output logic                      dbg_state
);

    // Handshake: a request (read or write) seen in IDLE is accepted on that edge; waitrequest
    // then drops for exactly the ACK cycle, where readdata is valid and the write commits.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    localparam logic [AVL_ADDR_WIDTH-1:0] A_CTRL   = AVL_ADDR_WIDTH'(0);
    localparam logic [AVL_ADDR_WIDTH-1:0] A_STATUS = AVL_ADDR_WIDTH'(1);
    localparam logic [AVL_ADDR_WIDTH-1:0] A_ERR    = AVL_ADDR_WIDTH'(2);
    localparam logic [AVL_ADDR_WIDTH-1:0] A_SCR_LO = AVL_ADDR_WIDTH'(4);
    localparam logic [AVL_ADDR_WIDTH-1:0] A_SCR_HI = AVL_ADDR_WIDTH'(4 + NUM_SCRATCH);
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
    localparam logic [AVL_ADDR_WIDTH-1:0] A_CNT    = AVL_ADDR_WIDTH'(3);
`endif

    state_e                                       state_q, state_d;
    logic [AVL_ADDR_WIDTH-1:0]                    addr_q;
    logic [AVL_DATA_WIDTH-1:0]                    wdata_q;
    logic                                         wr_q;
    logic                                         coll_q;
    logic [AVL_DATA_WIDTH-1:0]                    rdata_q, rdata_d;
    logic [2:0]                                   err_q, err_d;
    logic                                         irq_q;
    logic                                         go_q, go_d;
    logic [3:0]                                   code_q, code_d;
    logic [NUM_SCRATCH-1:0][AVL_DATA_WIDTH-1:0]   scratch_q, scratch_d;
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
    logic [AVL_DATA_WIDTH-1:0]                    cnt_q, cnt_d;
`endif

    logic                      accept;
    logic                      ack_mapped;
    logic [AVL_DATA_WIDTH-1:0] rd_val;
    logic [2:0]                err_set;
    logic [2:0]                err_clr;

    assign accept = (state_q == ST_IDLE) && (avl_read || avl_write);

    always_comb begin
        ack_mapped = (addr_q == A_CTRL) || (addr_q == A_STATUS) || (addr_q == A_ERR)
                     || ((addr_q >= A_SCR_LO) && (addr_q < A_SCR_HI));
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
        if (addr_q == A_CNT) begin
            ack_mapped = 1'b1;
        end
`endif
    end

    // Read mux on the live address: readdata is loaded on the accepting edge.
    always_comb begin
        rd_val = '0;
        if (avl_address == A_CTRL) begin
            rd_val = AVL_DATA_WIDTH'({code_q, 4'b0000});
        end
        if (avl_address == A_STATUS) begin
            rd_val = AVL_DATA_WIDTH'({cmd_busy, phy_status});
        end
        if (avl_address == A_ERR) begin
            rd_val = AVL_DATA_WIDTH'(err_q);
        end
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
        if (avl_address == A_CNT) begin
            rd_val = cnt_q;
        end
`endif
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (avl_address == AVL_ADDR_WIDTH'(4 + i)) begin
                rd_val = scratch_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        go_d      = 1'b0;
        code_d    = code_q;
        scratch_d = scratch_q;
        err_set   = 3'b000;
        err_clr   = 3'b000;
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACK;
                    if (avl_read && !avl_write) begin
                        rdata_d = rd_val;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (!ack_mapped) begin
                    err_set[0] = 1'b1;
                end
                if (wr_q && ack_mapped) begin
                    if (addr_q == A_CTRL) begin
                        if (cmd_busy) begin
                            err_set[1] = wdata_q[0];
                        end else begin
                            code_d = wdata_q[7:4];
                            go_d   = wdata_q[0];
                        end
                    end
                    if (addr_q == A_ERR) begin
                        err_clr = wdata_q[2:0];
                    end
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (addr_q == AVL_ADDR_WIDTH'(4 + i)) begin
                            scratch_d[i] = wdata_q;
                        end
                    end
                end
                if (coll_q) begin
                    err_set[2] = 1'b1;
                end
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
                if (wr_q && (addr_q == A_CNT)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + AVL_DATA_WIDTH'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // A set in the same cycle as a write-1-clear takes priority.
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            coll_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= '0;
            irq_q     <= 1'b0;
            go_q      <= 1'b0;
            code_q    <= '0;
            scratch_q <= '0;
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            irq_q     <= |err_d;
            go_q      <= go_d;
            code_q    <= code_d;
            scratch_q <= scratch_d;
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
            cnt_q     <= cnt_d;
`endif
            if (accept) begin
                addr_q  <= avl_address;
                wdata_q <= avl_writedata;
                wr_q    <= avl_write;
                coll_q  <= avl_read && avl_write;
            end
        end
    end

    assign avl_waitrequest = (state_q != ST_ACK);
    assign avl_readdata    = rdata_q;
    assign cmd_go          = go_q;
    assign cmd_code        = code_q;
    assign err_irq         = irq_q;
    assign dbg_state       = (state_q == ST_ACK);

endmodule

// File: tb/tb_seq_phy_csr_responder.sv
// Bench for seq_phy_csr_responder: directed scenarios plus random accesses against a register-map model.
module tb_seq_phy_csr_responder;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NS = 4;
    localparam int SW = 8;
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          avl_clk = 1'b0;
    logic          avl_reset_n = 1'b0;
    logic [AW-1:0] avl_address = '0;
    logic          avl_write = 1'b0;
    logic [DW-1:0] avl_writedata = '0;
    logic          avl_read = 1'b0;
    logic [DW-1:0] avl_readdata;
    logic          avl_waitrequest;
    logic [SW-1:0] phy_status = '0;
    logic          cmd_busy = 1'b0;
    logic          cmd_go;
    logic [3:0]    cmd_code;
    logic          err_irq;
    logic          dbg_state;

    seq_phy_csr_responder #(
        .AVL_DATA_WIDTH(DW),
        .AVL_ADDR_WIDTH(AW),
        .NUM_SCRATCH(NS),
        .STATUS_WIDTH(SW)
    ) dut (
        .avl_clk(avl_clk),
        .avl_reset_n(avl_reset_n),
        .avl_address(avl_address),
        .avl_write(avl_write),
        .avl_writedata(avl_writedata),
        .avl_read(avl_read),
        .avl_readdata(avl_readdata),
        .avl_waitrequest(avl_waitrequest),
        .phy_status(phy_status),
        .cmd_busy(cmd_busy),
        .cmd_go(cmd_go),
        .cmd_code(cmd_code),
        .err_irq(err_irq),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 avl_clk = ~avl_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    // bit DW flags a read whose data must be compared; low DW bits are the expected readdata
    logic [DW:0] exp_q[$];

    // reference model: register map contents
    logic [DW-1:0] m_scratch [NS];
    logic [2:0]    m_err;
    logic [3:0]    m_code;
    logic [DW-1:0] m_cnt;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_scratch[i] = '0;
        m_err  = '0;
        m_code = '0;
        m_cnt  = '0;
    endtask

    task automatic model_access(input bit rd, input bit wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input bit busy, input logic [SW-1:0] phy,
                                output logic [DW-1:0] rdv, output bit go);
        int ai;
        bit mapped;
        logic [2:0] set_b;
        logic [2:0] clr_b;
        ai     = int'(a);
        mapped = (ai <= 2) || (ai == 3 && CNT_EN) || (ai >= 4 && ai < 4 + NS);
        set_b  = 3'b000;
        clr_b  = 3'b000;
        rdv    = '0;
        go     = 1'b0;
        if (ai == 0) rdv = DW'(m_code) * 16;
        else if (ai == 1) rdv = DW'(phy) + (busy ? (DW'(1) << SW) : DW'(0));
        else if (ai == 2) rdv = DW'(m_err);
        else if (ai == 3 && CNT_EN) rdv = m_cnt;
        else if (mapped) rdv = m_scratch[ai - 4];
        if (!mapped) set_b[0] = 1'b1;
        if (wr && mapped) begin
            if (ai == 0) begin
                if (busy) begin
                    if (wd[0]) set_b[1] = 1'b1;
                end else begin
                    m_code = wd[7:4];
                    go     = wd[0];
                end
            end else if (ai == 2) begin
                clr_b = wd[2:0];
            end else if (ai >= 4) begin
                m_scratch[ai - 4] = wd;
            end
        end
        if (rd && wr) set_b[2] = 1'b1;
        m_err = (m_err & ~clr_b) | set_b;
        if (wr && ai == 3 && CNT_EN) m_cnt = '0;
        else m_cnt = m_cnt + 1;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge one cycle after ACK.
    task automatic do_access(input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input bit busy, input logic [SW-1:0] phy);
        logic [DW-1:0] rdv;
        bit go;
        int n;
        avl_read      = rd;
        avl_write     = wr;
        avl_address   = a;
        avl_writedata = wd;
        cmd_busy      = busy;
        phy_status    = phy;
        model_access(rd, wr, a, wd, busy, phy, rdv, go);
        exp_q.push_back({rd && !wr, rdv});
        check("wait_before_accept", DW'(avl_waitrequest), DW'(1));
        n = 0;
        do begin
            @(negedge avl_clk);
            n++;
        end while (avl_waitrequest && n < 8);
        check("wait_high_cycles", DW'(n), DW'(1));
        check("go_during_ack", DW'(cmd_go), DW'(0));
        avl_read  = 1'b0;
        avl_write = 1'b0;
        @(negedge avl_clk);
        check("wait_after_ack", DW'(avl_waitrequest), DW'(1));
        check("cmd_go", DW'(cmd_go), DW'(go));
        check("cmd_code", DW'(cmd_code), DW'(m_code));
        check("err_irq", DW'(err_irq), DW'(|m_err));
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge avl_clk);
            if (avl_reset_n && !avl_waitrequest) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: waitrequest low with no access pending at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e[DW]) check("readdata", avl_readdata, e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int sel;
        int kind;
        logic [AW-1:0] a;
        model_reset();
        repeat (3) @(negedge avl_clk);
        check("rst_waitrequest", DW'(avl_waitrequest), DW'(1));
        check("rst_readdata", avl_readdata, '0);
        check("rst_cmd_go", DW'(cmd_go), DW'(0));
        check("rst_cmd_code", DW'(cmd_code), DW'(0));
        check("rst_err_irq", DW'(err_irq), DW'(0));
        avl_reset_n = 1'b1;
        @(negedge avl_clk);

        // status read, scratch round trip
        do_access(1, 0, 16'd1, '0, 1, 8'hA5);
        do_access(0, 1, 16'd4, 32'hDEADBEEF, 0, 8'h00);
        do_access(1, 0, 16'd4, '0, 0, 8'h00);

        // command strobe, go-while-busy, W1C clear
        do_access(0, 1, 16'd0, 32'h31, 0, 8'h00);
        do_access(1, 0, 16'd0, '0, 0, 8'h00);
        do_access(0, 1, 16'd0, 32'h51, 1, 8'h00);
        do_access(1, 0, 16'd2, '0, 0, 8'h00);
        do_access(0, 1, 16'd2, 32'h2, 0, 8'h00);
        do_access(1, 0, 16'd2, '0, 0, 8'h00);

        // unmapped read, collision
        do_access(1, 0, 16'h0100, '0, 0, 8'h00);
        do_access(1, 0, 16'd2, '0, 0, 8'h00);
        do_access(1, 1, 16'd5, 32'h55, 0, 8'h00);
        do_access(1, 0, 16'd5, '0, 0, 8'h00);
        do_access(1, 0, 16'd2, '0, 0, 8'h00);
        do_access(0, 1, 16'd2, 32'h7, 0, 8'h00);

        // address 3: counter or unmapped
        do_access(0, 1, 16'd3, '0, 0, 8'h00);
        for (int i = 0; i < 5; i++) do_access(1, 0, 16'd4, '0, 0, 8'h00);
        do_access(1, 0, 16'd3, '0, 0, 8'h00);
        do_access(1, 0, 16'd2, '0, 0, 8'h00);
`ifdef SEQ_PHY_CSR_ACCESS_CNT_EN
        force dut.cnt_q = '1;
        #1;
        release dut.cnt_q;
        m_cnt = '1;
        do_access(1, 0, 16'd3, '0, 0, 8'h00);
        do_access(1, 0, 16'd3, '0, 0, 8'h00);
`endif
        do_access(0, 1, 16'd2, 32'h7, 0, 8'h00);

        // reset during the ACK of a write
        avl_write     = 1'b1;
        avl_address   = 16'd4;
        avl_writedata = 32'h77;
        @(posedge avl_clk);
        #1;
        check("ack_before_reset", DW'(avl_waitrequest), DW'(0));
        avl_reset_n = 1'b0;
        #1;
        check("wait_async_reset", DW'(avl_waitrequest), DW'(1));
        avl_write = 1'b0;
        repeat (2) @(negedge avl_clk);
        avl_reset_n = 1'b1;
        model_reset();
        @(negedge avl_clk);
        do_access(1, 0, 16'd4, '0, 0, 8'h00);
        do_access(1, 0, 16'd0, '0, 0, 8'h00);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            sel  = $urandom_range(0, 9);
            kind = $urandom_range(0, 9);
            if (sel < 8) a = AW'(sel);
            else if (sel == 8) a = 16'h0100;
            else a = AW'($urandom_range(8, 16'hFFFF));
            do_access(kind < 5 || kind == 9, kind >= 5, a, $urandom,
                      $urandom_range(0, 3) == 0, SW'($urandom));
        end

        repeat (3) @(negedge avl_clk);
        check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
